fsm_2bit: RTL and testbench

//  - 2-bit saturating up/down counter FSM (branch-direction predictor style) for the RISCV core.
//  - Input x is a 1-bit outcome per cycle: 1 = taken/strengthen, 0 = not-taken/weaken.
//  - Encoded state is exported directly. state[1] is the prediction bit: 1 = predict taken.
//  - Leaf block, used standalone or replicated inside a predictor table.

---
 rtl/fsm_2bit_pkg.sv | 11 +
 rtl/fsm_2bit.sv | 38 +++
 tb/tb_fsm_2bit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fsm_2bit_pkg.sv
// Shared 2-bit saturating-counter state codes, reused by the predictor tables.
package fsm_2bit_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SNT = 2'b00;
  localparam state_t WNT = 2'b01;
  localparam state_t WT  = 2'b10;
  localparam state_t ST  = 2'b11;

endpackage

// File: rtl/fsm_2bit.sv
// 2-bit saturating up/down counter used as a branch-direction predictor entry.
// state[1] is the prediction bit (1 = predict taken).
module fsm_2bit
  import fsm_2bit_pkg::*;
#(
  parameter state_t RESET_STATE = SNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic [1:0] state
);

  state_t nxt;

  always_comb begin
    nxt = RESET_STATE;
    case ({state, x})
      {SNT, 1'b0}: nxt = SNT;
      {SNT, 1'b1}: nxt = WNT;
      {WNT, 1'b0}: nxt = SNT;
      {WNT, 1'b1}: nxt = WT;
      {WT,  1'b0}: nxt = WNT;
      {WT,  1'b1}: nxt = ST;
      {ST,  1'b0}: nxt = WT;
      {ST,  1'b1}: nxt = ST;
      // Only reachable with X/Z on state or x; fall back to the reset code.
      default:     nxt = RESET_STATE;
    endcase
  end

  // State register: the only stage boundary, rst takes priority over x.
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= nxt;
  end

endmodule

// File: tb/tb_fsm_2bit.sv
// Bench for fsm_2bit: directed sequences with literal expectations plus
// randomized outcome/reset traffic checked every cycle against a clamp model.
module tb_fsm_2bit;

  logic       clk;
  logic       rst;
  logic       x;
  logic [1:0] state;

  int tests;
  int fails;

  int m;
  bit mvalid;

  fsm_2bit dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .state(state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural model: a counter clamped to 0..3, reset to 0.
  always @(posedge clk) begin
    if (rst) begin
      m      <= 0;
      mvalid <= 1'b1;
    end else if (mvalid) begin
      if (x) m <= (m + 1 > 3) ? 3 : m + 1;
      else   m <= (m - 1 < 0) ? 0 : m - 1;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      tests++;
      if (state !== m[1:0]) begin
        fails++;
        $display("FAIL model_cmp t=%0t state=%b expected=%b", $time, state, m[1:0]);
      end
    end
  end

  task automatic cyc(input logic r, input logic xv);
    rst = r;
    x   = xv;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [1:0] exp);
    tests++;
    if (state !== exp) begin
      fails++;
      $display("FAIL %s dut_state=%b expected=%b", name, state, exp);
    end
    tests++;
    if (m[1:0] !== exp) begin
      fails++;
      $display("FAIL %s_model model_state=%b expected=%b", name, m[1:0], exp);
    end
  endtask

  logic [1:0] up_exp   [5];
  logic [1:0] down_exp [5];
  logic       mix_x    [6];
  logic [1:0] mix_exp  [6];

  initial begin
    tests  = 0;
    fails  = 0;
    m      = 0;
    mvalid = 1'b0;
    up_exp   = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
    down_exp = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    mix_x    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    mix_exp  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};

    rst = 1'b1;
    x   = 1'b1;
    @(posedge clk);
    #2;
    cyc(1'b1, 1'b1);
    chk("reset_init", 2'b00);

    // Reset from strongly taken.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    chk("drive_to_st", 2'b11);
    cyc(1'b1, 1'b0);
    chk("reset_from_st", 2'b00);

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1);
      chk($sformatf("count_up_%0d", i), up_exp[i]);
    end

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0);
      chk($sformatf("count_down_%0d", i), down_exp[i]);
    end

    // Hysteresis: one not-taken from ST keeps the prediction bit set.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("hyst_weaken", 2'b10);
    tests++;
    if (state[1] !== 1'b1) begin
      fails++;
      $display("FAIL hyst_pred pred=%b expected=1", state[1]);
    end
    cyc(1'b0, 1'b1);
    chk("hyst_restrengthen", 2'b11);

    cyc(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, mix_x[i]);
      chk($sformatf("mixed_%0d", i), mix_exp[i]);
    end

    // Reset priority over x=1 at WT.
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("prio_at_wt", 2'b10);
    cyc(1'b1, 1'b1);
    chk("prio_reset", 2'b00);
    cyc(1'b0, 1'b1);
    chk("prio_release", 2'b01);

    // Randomized traffic with occasional mid-sequence resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
